// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared definitions for the weight fetch controller: FSM encoding, default
// array dimensions, SRAM address widths and output buffer depth.
package weight_fetch_ctrl_pkg;

  localparam int IFMAPS_DEF = 16;
  localparam int PIXELS_DEF = 25;
  localparam int KERN_AW    = 4;
  localparam int PIX_AW     = 6;
  localparam int BUF_DEPTH  = 2;
  localparam int BUF_CW     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    Q_IF,
    Q_IF_W,
    Q_PIX,
    Q_PIX_W,
    STREAM,
    DRAIN,
    FIN
  } fsm_state_t;

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Weight stream (valid/ready) plus weight SRAM port, seen from the controller
// (master) and from the SRAM/consumer environment (slave).
interface weight_fetch_ctrl_if #(
  parameter int DW = 8
);
  import weight_fetch_ctrl_pkg::*;

  logic [DW-1:0]      w_data;
  logic               w_valid;
  logic               w_ready;
  logic [KERN_AW-1:0] w_kern;
  logic [PIX_AW-1:0]  w_pix;
  logic               w_last;

  logic               sram_cs;
  logic               sram_we;
  logic               sram_rd;
  logic               sram_ifmaps;
  logic               sram_pixels;
  logic [KERN_AW-1:0] sram_kern_addr;
  logic [PIX_AW-1:0]  sram_pix_addr;
  logic [DW-1:0]      sram_data_out;
  logic [DW-1:0]      sram_data_in;

  modport master (
    output w_data, w_valid, w_kern, w_pix, w_last,
    input  w_ready,
    output sram_cs, sram_we, sram_rd, sram_ifmaps, sram_pixels,
    output sram_kern_addr, sram_pix_addr, sram_data_out,
    input  sram_data_in
  );

  modport slave (
    input  w_data, w_valid, w_kern, w_pix, w_last,
    output w_ready,
    input  sram_cs, sram_we, sram_rd, sram_ifmaps, sram_pixels,
    input  sram_kern_addr, sram_pix_addr, sram_data_out,
    output sram_data_in
  );

endinterface

// File: rtl/weight_fetch_ctrl_skid_buf.sv
// Two-entry FIFO holding returned weights with their (kernel, pixel, last) tag.
// Head outputs read as zero while empty so the stream is quiet after reset.
module weight_skid_buf
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               push,
  input  logic [DW-1:0]      pushData,
  input  logic [KERN_AW-1:0] pushKern,
  input  logic [PIX_AW-1:0]  pushPix,
  input  logic               pushLast,
  input  logic               pop,
  output logic               headValid,
  output logic [DW-1:0]      headData,
  output logic [KERN_AW-1:0] headKern,
  output logic [PIX_AW-1:0]  headPix,
  output logic               headLast,
  output logic [BUF_CW-1:0]  count
);
  localparam int PW = $clog2(BUF_DEPTH);

  logic [DW-1:0]      memData [BUF_DEPTH];
  logic [KERN_AW-1:0] memKern [BUF_DEPTH];
  logic [PIX_AW-1:0]  memPix  [BUF_DEPTH];
  logic               memLast [BUF_DEPTH];
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      memData[wrPtr] <= pushData;
      memKern[wrPtr] <= pushKern;
      memPix[wrPtr]  <= pushPix;
      memLast[wrPtr] <= pushLast;
    end
  end

  assign headValid = (count != '0);
  assign headData  = headValid ? memData[rdPtr] : '0;
  assign headKern  = headValid ? memKern[rdPtr] : '0;
  assign headPix   = headValid ? memPix[rdPtr]  : '0;
  assign headLast  = headValid ? memLast[rdPtr] : 1'b0;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM reader: queries kernel/pixel counts, walks every (k,p) address
// kernel-major and streams the returned weights over a valid/ready port.
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int IFMAPS = IFMAPS_DEF,
  parameter int PIXELS = PIXELS_DEF,
  parameter int DW     = 8
) (
  input  logic Clk,
  input  logic Rst,
  input  logic start,
  output logic busy,
  output logic done,
  weight_fetch_ctrl_if.master bus
);
  localparam int IF_CW  = $clog2(IFMAPS + 1);
  localparam int PIX_CW = $clog2(PIXELS + 1);

  function automatic logic [IF_CW-1:0] satIf(input logic [DW-1:0] raw);
    return (int'(raw) > IFMAPS) ? IF_CW'(IFMAPS) : IF_CW'(raw);
  endfunction

  function automatic logic [PIX_CW-1:0] satPix(input logic [DW-1:0] raw);
    return (int'(raw) > PIXELS) ? PIX_CW'(PIXELS) : PIX_CW'(raw);
  endfunction

  fsm_state_t         state;
  logic [KERN_AW-1:0] kIdx;
  logic [PIX_AW-1:0]  pIdx;
  logic [IF_CW-1:0]   nIf;
  logic [PIX_CW-1:0]  nPix;
  logic               vld_p1;
  logic [KERN_AW-1:0] kern_p1;
  logic [PIX_AW-1:0]  pix_p1;
  logic               last_p1;

  logic [IF_CW-1:0]   ifSat;
  logic [PIX_CW-1:0]  pixSat;
  logic               kAtEnd, pAtEnd, issue, pop, headValid;
  logic [BUF_CW-1:0]  bufCount;
  logic [BUF_CW:0]    occupancy;
  logic [DW-1:0]      headData;
  logic [KERN_AW-1:0] headKern;
  logic [PIX_AW-1:0]  headPix;
  logic               headLast;

  assign ifSat  = satIf(bus.sram_data_in);
  assign pixSat = satPix(bus.sram_data_in);
  assign kAtEnd = (IF_CW'(kIdx) == nIf - IF_CW'(1));
  assign pAtEnd = (pIdx == PIX_AW'(nPix - PIX_CW'(1)));
  assign pop    = headValid && bus.w_ready;

  // Slots committed after this cycle's pop; a read needs one free slot since
  // its data lands in the buffer two edges later.
  assign occupancy = {1'b0, bufCount} + {{BUF_CW{1'b0}}, vld_p1} - {{BUF_CW{1'b0}}, pop};
  assign issue     = (state == STREAM) && (occupancy < (BUF_CW+1)'(BUF_DEPTH));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      kIdx   <= '0;
      pIdx   <= '0;
      nIf    <= '0;
      nPix   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      case (state)
        IDLE: if (start) begin
          state <= Q_IF;
          kIdx  <= '0;
          pIdx  <= '0;
        end
        Q_IF:   state <= Q_IF_W;
        Q_IF_W: begin
          nIf   <= ifSat;
          state <= (ifSat == '0) ? FIN : Q_PIX;
        end
        Q_PIX:   state <= Q_PIX_W;
        Q_PIX_W: begin
          nPix  <= pixSat;
          state <= (pixSat == '0) ? FIN : STREAM;
        end
        STREAM: if (issue) begin
          if (pAtEnd) begin
            pIdx <= '0;
            if (kAtEnd) state <= DRAIN;
            else        kIdx  <= kIdx + 1'b1;
          end else begin
            pIdx <= pIdx + 1'b1;
          end
        end
        DRAIN:   if (bufCount == '0 && !vld_p1) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // p0 -> p1: tag of the read whose data appears on sram_data_in next cycle
  always_ff @(posedge Clk) begin
    if (issue) begin
      kern_p1 <= kIdx;
      pix_p1  <= pIdx;
      last_p1 <= kAtEnd && pAtEnd;
    end
  end

  // p1 -> buffer: returned word is captured together with its tag
  weight_skid_buf #(.DW(DW)) uBuf (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (vld_p1),
    .pushData  (bus.sram_data_in),
    .pushKern  (kern_p1),
    .pushPix   (pix_p1),
    .pushLast  (last_p1),
    .pop       (pop),
    .headValid (headValid),
    .headData  (headData),
    .headKern  (headKern),
    .headPix   (headPix),
    .headLast  (headLast),
    .count     (bufCount)
  );

  assign bus.w_valid        = headValid;
  assign bus.w_data         = headData;
  assign bus.w_kern         = headKern;
  assign bus.w_pix          = headPix;
  assign bus.w_last         = headLast;

  assign bus.sram_rd        = issue;
  assign bus.sram_ifmaps    = (state == Q_IF);
  assign bus.sram_pixels    = (state == Q_PIX);
  assign bus.sram_cs        = issue || (state == Q_IF) || (state == Q_PIX);
  assign bus.sram_we        = 1'b0;
  assign bus.sram_data_out  = '0;
  assign bus.sram_kern_addr = kIdx;
  assign bus.sram_pix_addr  = pIdx;

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Initiator/reader side of the weight SRAM port; the SRAM is the responder.
- On start, queries the SRAM for its ifmap and pixel counts, then sequences reads over every (kernel, pixel) address, kernel-major.
- Streams weights to the PE/MAC array over a valid/ready interface, absorbing the SRAM's one-cycle registered read latency with a 2-entry output buffer.

Parameters:
- IFMAPS, 16, maximum kernel count; SRAM kernel address width is 4.
- PIXELS, 25, maximum pixels per kernel; SRAM pixel address width is 6.
- DW, 8, weight data width.

Ports:
- Clk  in  1  system clock; the single clock.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream all weights; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- w_data  out  DW  weight value.
- w_valid  out  1  w_data/w_kern/w_pix are valid.
- w_ready  in  1  consumer accepts the beat when w_valid&&w_ready.
- w_kern  out  4  kernel index of the beat.
- w_pix  out  6  pixel index of the beat.
- w_last  out  1  final beat of the whole stream.
- sram_cs  out  1  chip select.
- sram_we  out  1  write enable; constant 0.
- sram_rd  out  1  read strobe.
- sram_ifmaps  out  1  ifmap-count query.
- sram_pixels  out  1  pixel-count query.
- sram_kern_addr  out  4  kernel address.
- sram_pix_addr  out  6  pixel address.
- sram_data_out  out  DW  SRAM write data; constant 0.
- sram_data_in  in  DW  SRAM registered read data.

Behaviour:
- **Reset:** every output is 0. The FSM goes to IDLE, the buffer empties, counters clear, and any in-flight read is discarded. Reset mid-stream aborts with no done pulse.
- **SRAM protocol:**
  - A request is the SRAM strobes held for exactly one cycle, N.
  - sram_data_in is captured on the edge ending cycle N+1.
  - At most one request is issued per cycle.
  - sram_cs is high only in request cycles.
  - The query strobes and sram_rd are never asserted together.
- **FSM states:** IDLE -> Q_IF -> Q_IF_W -> Q_PIX -> Q_PIX_W -> STREAM -> DRAIN -> FIN -> IDLE.
  - IDLE: waits for start; start accepted -> Q_IF.
  - Q_IF: asserts cs and ifmaps for one cycle.
  - Q_IF_W: captures n_if = min(sram_data_in, IFMAPS).
  - Q_PIX and Q_PIX_W: same pattern, capturing n_pix = min(sram_data_in, PIXELS).
  - Zero count: if n_if==0 or n_pix==0, go to FIN directly; no beats are produced and done still pulses.
  - STREAM: issues reads at (k,p), starting at (0,0). p increments and wraps to 0 at n_pix-1, at which point k increments. After issuing (n_if-1, n_pix-1) -> DRAIN.
  - DRAIN: waits until the buffer is empty and nothing is in flight -> FIN.
  - FIN: done=1 for one cycle, busy=0 from the next cycle -> IDLE.
- **Flow control:**
  - A read is issued only if buffer_count + inflight < 2.
  - A returning word is written into the buffer tagged with its (k,p) and last flag.
  - The buffer head drives the w_* outputs.
  - Simultaneous push and pop in one cycle is legal and leaves the count unchanged.
  - Under continuous w_ready the stream sustains 1 beat/cycle.
  - Steady-state latency is 2 cycles from the first read issue to the first w_valid.
- **Output stability:** w_* stay stable while w_valid && !w_ready. w_last is 1 only on (n_if-1, n_pix-1).
- start during busy has no effect.
- Counters never exceed their clamped limits; no address outside [0,n-1] is driven.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - the IFMAPS/PIXELS defaults and derived address widths (4, 6);
  - the buffer depth constant (2).
- One natural sub-module, weight_skid_buf: 2-entry FIFO of {data, kern, pix, last} with push/pop/count.

Test Plan:
1. SRAM model returns counts 2/3; w_ready=1 -> exactly 6 beats in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with matching preloaded data; w_last only on (1,2); done pulses once; busy falls the cycle after done.
2. Model returns counts 16/25; w_ready toggled randomly -> 400 beats, no loss/duplication; w_* stable across every stalled cycle; buffer never exceeds 2.
3. Model returns counts 40/30 -> clamped to 16×25 = 400 beats; max addresses driven are kern 15, pix 24.
4. Model returns n_if=0 -> no sram_rd ever; w_valid stays 0; done pulses exactly once.
5. Assert Rst after beat 7 of a 4×4 run, then start again -> all outputs 0 the cycle after reset, no done for the aborted run, new run produces 16 correct beats from (0,0).
6. Pulse start on cycles 3 and 10 of an active run -> single stream only; sram_we and sram_data_out stay 0 throughout.
